input_conditioner: RTL and testbench

Front end of the Rail Rush control path. It merges four raw push-buttons and a byte-command stream from the CV gesture link (valid/ready, fed by the UART receiver) into the clean control signals the player stage consumes: move_left_pulse, move_right_pulse, jump_pulse and slide_hold. Buttons are synchronised, debounced and edge-detected. CV slide commands become a timed hold.

---
 rtl/rail_rush_pkg.sv | 19 +
 rtl/button_debouncer.sv | 44 ++++
 rtl/input_conditioner.sv | 106 ++++++++++
 tb/tb_input_conditioner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rail_rush_pkg.sv
// Shared constants for the Rail Rush control path: CV command bytes and button indices.
package rail_rush_pkg;

  localparam logic [7:0] CMD_LEFT    = 8'h4C;
  localparam logic [7:0] CMD_RIGHT   = 8'h52;
  localparam logic [7:0] CMD_JUMP    = 8'h4A;
  localparam logic [7:0] CMD_SLIDE   = 8'h53;
  localparam logic [7:0] CMD_NOSLIDE = 8'h4E;

  typedef enum logic [1:0] {
    BTN_LEFT  = 2'd0,
    BTN_RIGHT = 2'd1,
    BTN_JUMP  = 2'd2,
    BTN_SLIDE = 2'd3
  } btn_idx_e;

  localparam int NUM_BTN = 4;

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-FF synchroniser, stability counter, debounced level and a
// registered one-cycle rise flag that is set on the same edge the level rises.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [DB_W-1:0] LAST_COUNT = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic [DB_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      count   <= '0;
      stable  <= 1'b0;
      rise    <= 1'b0;
    end else begin
      // stage p0/p1: metastability chain; the counter watches sync_p1 only
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      if (sync_p1 == stable) begin
        count <= '0;
      end else if (count == LAST_COUNT) begin
        stable <= sync_p1;
        count  <= '0;
        rise   <= sync_p1;
      end else begin
        count <= count + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Rail Rush front end: merges debounced buttons and CV command bytes into
// registered move/jump pulses, a slide hold level and a command error pulse.
module input_conditioner
  import rail_rush_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20,
  parameter int CV_SLIDE_CYCLES = 25000000,
  parameter int SL_W            = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_slide,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       move_left_pulse,
  output logic       move_right_pulse,
  output logic       jump_pulse,
  output logic       slide_hold,
  output logic       cmd_error
);

  localparam logic [SL_W-1:0] SLIDE_LOAD = SL_W'(CV_SLIDE_CYCLES);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_stable;
  logic [NUM_BTN-1:0] btn_rise;
  logic [2:0]         stable_unused;

  assign btn_raw = {btn_slide, btn_jump, btn_right, btn_left};
  // Only the slide button's debounced level matters here; the others are edge-only.
  assign stable_unused = btn_stable[2:0];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (btn_raw[g]),
      .stable(btn_stable[g]),
      .rise  (btn_rise[g])
    );
  end

  logic            cmd_busy;
  logic            accept;
  logic            hit_left, hit_right, hit_jump, hit_slide, hit_noslide, hit_err;
  logic [SL_W-1:0] slide_timer;

  // A one-cycle bubble after every accept limits the link to one byte per two cycles.
  assign cmd_ready = ~reset & ~cmd_busy;
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    hit_left    = 1'b0;
    hit_right   = 1'b0;
    hit_jump    = 1'b0;
    hit_slide   = 1'b0;
    hit_noslide = 1'b0;
    hit_err     = 1'b0;
    if (accept) begin
      case (cmd_data)
        CMD_LEFT:    hit_left    = 1'b1;
        CMD_RIGHT:   hit_right   = 1'b1;
        CMD_JUMP:    hit_jump    = 1'b1;
        CMD_SLIDE:   hit_slide   = 1'b1;
        CMD_NOSLIDE: hit_noslide = 1'b1;
        default:     hit_err     = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_busy         <= 1'b0;
      slide_timer      <= '0;
      move_left_pulse  <= 1'b0;
      move_right_pulse <= 1'b0;
      jump_pulse       <= 1'b0;
      slide_hold       <= 1'b0;
      cmd_error        <= 1'b0;
    end else begin
      // stage p1: output registers; OR-merge makes coincident sources one pulse
      cmd_busy         <= accept;
      move_left_pulse  <= btn_rise[BTN_LEFT]  | hit_left;
      move_right_pulse <= btn_rise[BTN_RIGHT] | hit_right;
      jump_pulse       <= btn_rise[BTN_JUMP]  | hit_jump;
      cmd_error        <= hit_err;
      slide_hold       <= btn_stable[BTN_SLIDE] | (slide_timer != '0) | hit_slide;
      if (hit_slide) begin
        slide_timer <= SLIDE_LOAD;
      end else if (hit_noslide) begin
        slide_timer <= '0;
      end else if (slide_timer != '0) begin
        slide_timer <= slide_timer - SL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with short debounce and slide timings.
module tb_input_conditioner;
  import rail_rush_pkg::*;

  localparam int DEB = 4;
  localparam int SLD = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0, btn_slide = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, move_left_pulse, move_right_pulse, jump_pulse, slide_hold, cmd_error;
  logic [5:0] obs;

  typedef struct {
    logic [5:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .DB_W           (3),
    .CV_SLIDE_CYCLES(SLD),
    .SL_W           (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .btn_jump        (btn_jump),
    .btn_slide       (btn_slide),
    .cmd_valid       (cmd_valid),
    .cmd_data        (cmd_data),
    .cmd_ready       (cmd_ready),
    .move_left_pulse (move_left_pulse),
    .move_right_pulse(move_right_pulse),
    .jump_pulse      (jump_pulse),
    .slide_hold      (slide_hold),
    .cmd_error       (cmd_error)
  );

  always #5 clock = ~clock;

  assign obs = {cmd_ready, move_left_pulse, move_right_pulse, jump_pulse, slide_hold, cmd_error};

  function automatic logic [5:0] ev(input logic rdy, input logic l, input logic r,
                                    input logic j, input logic s, input logic err);
    return {rdy, l, r, j, s, err};
  endfunction

  // Outputs are listed as rdy/left/right/jump/slide/err in every report.
  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      reset = (i < 3);
      exp_q.push_back('{ev(i >= 3, 0, 0, 0, 0, 0), $sformatf("reset c%0d", i)});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_jump_press();
    exp_t e;
    for (int i = 0; i < 18; i++) begin
      btn_jump = (i < 10);
      exp_q.push_back('{ev(1, 0, 0, i == DEB + 2, 0, 0), $sformatf("jump c%0d", i)});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      btn_left = (i < 3) || (i >= 4 && i < 7);
      exp_q.push_back('{ev(1, 0, 0, 0, 0, 0), $sformatf("glitch c%0d", i)});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i <= 2);
      cmd_data  = (i == 0) ? CMD_RIGHT : CMD_JUMP;
      exp_q.push_back('{ev(!(i == 0 || i == 2), 0, i == 0, i == 2, 0, 0),
                        $sformatf("b2b c%0d", i)});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_slide_cmd();
    exp_t       e;
    int         t2;
    int         last;
    logic [7:0] b2;
    for (int sc = 0; sc < 3; sc++) begin
      t2   = (sc == 1) ? 4 : (sc == 2) ? 6 : -1;
      b2   = (sc == 1) ? CMD_SLIDE : CMD_NOSLIDE;
      last = (sc == 0) ? SLD : (sc == 1) ? 4 + SLD : 6;
      for (int i = 0; i < 18; i++) begin
        cmd_valid = (i == 0) || (i == t2);
        cmd_data  = (i == 0) ? CMD_SLIDE : b2;
        exp_q.push_back('{ev(!cmd_valid, 0, 0, 0, i <= last, 0),
                          $sformatf("slide s%0d c%0d", sc, i)});
        @(posedge clock); #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s: got %b required %b", e.tag, obs, e.v);
        end
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_error_and_merge();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = (i == 0);
      cmd_data  = 8'h41;
      exp_q.push_back('{ev(i != 0, 0, 0, 0, 0, i == 0), $sformatf("error c%0d", i)});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b", e.tag, obs, e.v);
      end
    end
    for (int i = 0; i < 20; i++) begin
      btn_left  = (i < 12);
      cmd_valid = (i == DEB + 2);
      cmd_data  = CMD_LEFT;
      exp_q.push_back('{ev(i != DEB + 2, i == DEB + 2, 0, 0, 0, 0), $sformatf("merge c%0d", i)});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b", e.tag, obs, e.v);
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_slide();
    exp_t e;
    btn_slide = 1'b1;
    for (int i = 0; i < 16; i++) begin
      reset     = (i < 3);
      cmd_valid = (i == 12);
      cmd_data  = CMD_NOSLIDE;
      exp_q.push_back('{ev((i >= 3) && (i != 12), 0, 0, 0, i >= 3 + DEB + 2, 0),
                        $sformatf("held-reset c%0d", i)});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b", e.tag, obs, e.v);
      end
    end
    btn_slide = 1'b0;
    for (int j = 0; j < 25; j++) begin
      reset     = (j == 13) || (j == 14);
      cmd_valid = (j == 10);
      cmd_data  = CMD_SLIDE;
      exp_q.push_back('{ev(!(j == 10 || j == 13 || j == 14), 0, 0, 0,
                           (j <= DEB + 1) || (j >= 10 && j <= 12), 0),
                        $sformatf("mid-slide-reset c%0d", j)});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b", e.tag, obs, e.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jump_press();
    test_glitch();
    test_back_to_back();
    test_slide_cmd();
    test_error_and_merge();
    test_reset_slide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
